pipe_skid_stage: RTL

Parametrised pipeline stage register that generalises the fixed MEM/WB stage register into a reusable block. It carries a bundled payload with a valid/ready handshake, stall via backpressure, synchronous flush, and an optional 2-entry skid buffer so `in_ready` is a registered signal. It is instantiated between any two RISC-V pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the payload packed from the stage's control and data fields.

---
 rtl/pipe_skid_stage_pkg.sv | 68 ++++++
 rtl/pipe_skid_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for pipeline stage registers: occupancy/state encodings and
// per-stage payload structs that get packed into a pipe_skid_stage DATA_W bus.
package pipe_pkg;

    typedef logic [1:0] occ_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } ifid_payload_t;

    typedef struct packed {
        logic             regwen;
        logic             memwen;
        logic [3:0]       alu_sel;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  data_a;
        logic [XLEN-1:0]  data_b;
    } idex_payload_t;

    typedef struct packed {
        logic             regwen;
        logic             memwen;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  data_b;
        logic [XLEN-1:0]  alu_out;
    } exmem_payload_t;

    typedef struct packed {
        logic             regwen;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  data_b;
        logic [XLEN-1:0]  alu_out;
        logic [XLEN-1:0]  wbdata;
    } memwb_payload_t;

    // Widths to use as DATA_W when instantiating a stage for each boundary.
    localparam int IFID_W  = $bits(ifid_payload_t);
    localparam int IDEX_W  = $bits(idex_payload_t);
    localparam int EXMEM_W = $bits(exmem_payload_t);
    localparam int MEMWB_W = $bits(memwb_payload_t);

    function automatic occ_t occ_of(input skid_state_e st);
        occ_t occ;
        case (st)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Reusable pipeline stage register with valid/ready handshake, flush, and an
// optional 2-entry skid buffer that makes in_ready a pure flop output.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output occ_t              occupancy
);

    generate
        if (SKID != 0) begin : g_skid
            skid_state_e       state_reg;
            logic [DATA_W-1:0] main_reg;
            logic [DATA_W-1:0] skid_reg;
            logic              out_valid_reg;
            logic              in_ready_reg;
            occ_t              occ_reg;
            logic              accept;
            logic              pop;

            assign accept = in_valid & in_ready_reg;
            assign pop    = out_valid_reg & out_ready;

            // main_reg always holds the oldest entry; skid_reg only catches the
            // one beat that arrives while downstream is stalled.
            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    state_reg     <= EMPTY;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    occ_reg       <= occ_of(EMPTY);
                    if (CLR_DATA != 0) begin
                        main_reg <= '0;
                        skid_reg <= '0;
                    end
                end else begin
                    case (state_reg)
                        EMPTY: begin
                            if (accept) begin
                                main_reg      <= in_data;
                                state_reg     <= ONE;
                                out_valid_reg <= 1'b1;
                                occ_reg       <= occ_of(ONE);
                            end
                        end
                        ONE: begin
                            if (accept && !pop) begin
                                skid_reg     <= in_data;
                                state_reg    <= FULL;
                                in_ready_reg <= 1'b0;
                                occ_reg      <= occ_of(FULL);
                            end else if (accept) begin
                                main_reg <= in_data;
                            end else if (pop) begin
                                state_reg     <= EMPTY;
                                out_valid_reg <= 1'b0;
                                occ_reg       <= occ_of(EMPTY);
                            end
                        end
                        FULL: begin
                            if (pop) begin
                                main_reg     <= skid_reg;
                                state_reg    <= ONE;
                                in_ready_reg <= 1'b1;
                                occ_reg      <= occ_of(ONE);
                            end
                        end
                        default: begin
                            state_reg     <= EMPTY;
                            out_valid_reg <= 1'b0;
                            in_ready_reg  <= 1'b1;
                            occ_reg       <= occ_of(EMPTY);
                        end
                    endcase
                end
            end

            assign in_ready  = in_ready_reg;
            assign out_valid = out_valid_reg;
            assign out_data  = main_reg;
            assign occupancy = occ_reg;
        end else begin : g_single
            logic [DATA_W-1:0] main_reg;
            logic              valid_reg;
            logic              ready;
            logic              accept;
            logic              pop;

            // A pop this cycle frees the register, so ready looks through to out_ready.
            assign ready  = !valid_reg | out_ready;
            assign accept = in_valid & ready;
            assign pop    = valid_reg & out_ready;

            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    valid_reg <= 1'b0;
                    if (CLR_DATA != 0) begin
                        main_reg <= '0;
                    end
                end else if (accept) begin
                    main_reg  <= in_data;
                    valid_reg <= 1'b1;
                end else if (pop) begin
                    valid_reg <= 1'b0;
                end
            end

            assign in_ready  = ready;
            assign out_valid = valid_reg;
            assign out_data  = main_reg;
            assign occupancy = {1'b0, valid_reg};
        end
    endgenerate

endmodule
